// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one waitrequest-style memory bus between the
// instruction-fetch and load/store paths, with a per-access stall watchdog.
module mem_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_req,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  output logic        instr_done,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_address,
  input  logic [31:0] data_writedata,
  input  logic [3:0]  data_byteenable,
  output logic [31:0] data_readdata,
  output logic        data_done,
  output logic [31:0] bus_address,
  output logic        bus_read,
  output logic        bus_write,
  output logic [31:0] bus_writedata,
  output logic [3:0]  bus_byteenable,
  input  logic        bus_waitrequest,
  input  logic [31:0] bus_readdata,
  output logic        timeout_error
);

  typedef enum logic [1:0] {IDLE, BUS_I, BUS_D, RESP} state_t;

  localparam logic [15:0] LP_WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic        r_last_data;
  logic [31:0] r_addr;
  logic        r_rd;
  logic        r_wr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_idone;
  logic        r_ddone;
  logic [31:0] r_irdata;
  logic [31:0] r_drdata;
  logic        r_to;
  logic [15:0] r_wd_cnt;

  logic w_dreq;
  logic w_grant_i;
  logic w_abort;

  assign w_dreq    = data_read | data_write;
  // Fetch wins when alone, or when contended and data was served last.
  assign w_grant_i = instr_req & (~w_dreq | r_last_data);
  // The edge that would bring the stall count up to the limit aborts.
  assign w_abort   = bus_waitrequest & (r_wd_cnt == LP_WD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_last_data <= 1'b1;
      r_addr      <= '0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_idone     <= 1'b0;
      r_ddone     <= 1'b0;
      r_irdata    <= '0;
      r_drdata    <= '0;
      r_to        <= 1'b0;
      r_wd_cnt    <= '0;
    end else begin
      r_idone <= 1'b0;
      r_ddone <= 1'b0;
      case (r_state)
        IDLE: begin
          if (instr_req || w_dreq) begin
            r_wd_cnt <= '0;
            if (w_grant_i) begin
              r_state     <= BUS_I;
              r_last_data <= 1'b0;
              r_addr      <= instr_address;
              r_rd        <= 1'b1;
              r_wr        <= 1'b0;
              r_be        <= 4'b1111;
            end else begin
              r_state     <= BUS_D;
              r_last_data <= 1'b1;
              r_addr      <= data_address;
              r_rd        <= ~data_write;
              r_wr        <= data_write;
              r_wdata     <= data_writedata;
              r_be        <= data_byteenable;
            end
          end
        end
        BUS_I, BUS_D: begin
          if (bus_waitrequest) r_wd_cnt <= r_wd_cnt + 16'd1;
          if (!bus_waitrequest || w_abort) begin
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_state <= RESP;
            if (w_abort) r_to <= 1'b1;
            if (r_state == BUS_I) begin
              r_idone  <= 1'b1;
              r_irdata <= w_abort ? 32'h0 : bus_readdata;
            end else begin
              r_ddone <= 1'b1;
              if (w_abort)   r_drdata <= 32'h0;
              else if (r_rd) r_drdata <= bus_readdata;
            end
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign instr_readdata = r_irdata;
  assign instr_done     = r_idone;
  assign data_readdata  = r_drdata;
  assign data_done      = r_ddone;
  assign bus_address    = r_addr;
  assign bus_read       = r_rd;
  assign bus_write      = r_wr;
  assign bus_writedata  = r_wdata;
  assign bus_byteenable = r_be;
  assign timeout_error  = r_to;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: per-cycle vector table plus hand-written
// arbitration, watchdog and mid-access reset sequences.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_req;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        instr_done;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_address;
  logic [31:0] data_writedata;
  logic [3:0]  data_byteenable;
  logic [31:0] data_readdata;
  logic        data_done;
  logic [31:0] bus_address;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_writedata;
  logic [3:0]  bus_byteenable;
  logic        bus_waitrequest;
  logic [31:0] bus_readdata;
  logic        timeout_error;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .instr_req(instr_req), .instr_address(instr_address),
    .instr_readdata(instr_readdata), .instr_done(instr_done),
    .data_read(data_read), .data_write(data_write),
    .data_address(data_address), .data_writedata(data_writedata),
    .data_byteenable(data_byteenable), .data_readdata(data_readdata),
    .data_done(data_done), .bus_address(bus_address),
    .bus_read(bus_read), .bus_write(bus_write),
    .bus_writedata(bus_writedata), .bus_byteenable(bus_byteenable),
    .bus_waitrequest(bus_waitrequest), .bus_readdata(bus_readdata),
    .timeout_error(timeout_error)
  );

  typedef struct {
    logic        ireq, dr, dw, wt;
    logic [31:0] rdata;
    logic        e_rd, e_wr, e_idone, e_ddone;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_irdata, e_drdata;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t v(input logic ireq, dr, dw, wt, input logic [31:0] rdata,
                             input logic e_rd, e_wr, e_idone, e_ddone,
                             input logic [31:0] e_addr, input logic [3:0] e_be,
                             input logic [31:0] e_irdata, e_drdata);
    vec_t r;
    r.ireq = ireq; r.dr = dr; r.dw = dw; r.wt = wt; r.rdata = rdata;
    r.e_rd = e_rd; r.e_wr = e_wr; r.e_idone = e_idone; r.e_ddone = e_ddone;
    r.e_addr = e_addr; r.e_be = e_be; r.e_irdata = e_irdata; r.e_drdata = e_drdata;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ireq, dr, dw, wt, input logic [31:0] rdata);
    instr_req = ireq; data_read = dr; data_write = dw;
    bus_waitrequest = wt; bus_readdata = rdata;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 32'h0);
    instr_address   = 32'hBFC00000;
    data_address    = 32'h00001000;
    data_writedata  = 32'hDEADBEEF;
    data_byteenable = 4'b0011;

    //           ireq dr dw wt rdata          rd wr id dd addr          be     irdata        drdata
    vecs[0]  = v(1, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0);
    vecs[1]  = v(1, 0, 0, 0, 32'h24020005,   1, 0, 0, 0, 32'hBFC00000, 4'hF, 32'h0,        32'h0);
    vecs[2]  = v(0, 0, 0, 0, 32'h0,          0, 0, 1, 0, 32'h0,        4'h0, 32'h24020005, 32'h0);
    vecs[3]  = v(0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,        4'h0, 32'h24020005, 32'h0);
    vecs[4]  = v(0, 0, 1, 0, 32'h0,          0, 0, 0, 0, 32'h0,        4'h0, 32'h24020005, 32'h0);
    vecs[5]  = v(0, 0, 1, 1, 32'h0,          0, 1, 0, 0, 32'h00001000, 4'h3, 32'h24020005, 32'h0);
    vecs[6]  = v(0, 0, 1, 1, 32'h0,          0, 1, 0, 0, 32'h00001000, 4'h3, 32'h24020005, 32'h0);
    vecs[7]  = v(0, 0, 1, 1, 32'h0,          0, 1, 0, 0, 32'h00001000, 4'h3, 32'h24020005, 32'h0);
    vecs[8]  = v(0, 0, 1, 0, 32'h12345678,   0, 1, 0, 0, 32'h00001000, 4'h3, 32'h24020005, 32'h0);
    vecs[9]  = v(0, 0, 0, 0, 32'h0,          0, 0, 0, 1, 32'h0,        4'h0, 32'h24020005, 32'h0);
    vecs[10] = v(0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,        4'h0, 32'h24020005, 32'h0);
    vecs[11] = v(0, 1, 1, 0, 32'h0,          0, 0, 0, 0, 32'h0,        4'h0, 32'h24020005, 32'h0);
    vecs[12] = v(0, 1, 1, 0, 32'h00000055,   0, 1, 0, 0, 32'h00001000, 4'h3, 32'h24020005, 32'h0);
    vecs[13] = v(0, 0, 0, 0, 32'h0,          0, 0, 0, 1, 32'h0,        4'h0, 32'h24020005, 32'h0);
    vecs[14] = v(0, 1, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,        4'h0, 32'h24020005, 32'h0);
    vecs[15] = v(0, 1, 0, 0, 32'hCAFEF00D,   1, 0, 0, 0, 32'h00001000, 4'h3, 32'h24020005, 32'h0);
    vecs[16] = v(0, 0, 0, 0, 32'h0,          0, 0, 0, 1, 32'h0,        4'h0, 32'h24020005, 32'hCAFEF00D);
    vecs[17] = v(0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,        4'h0, 32'h24020005, 32'hCAFEF00D);

    step(); step();
    reset = 1'b0;

    // Per-cycle vectors: fetch, stalled store, read+write collision, load
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].ireq, vecs[i].dr, vecs[i].dw, vecs[i].wt, vecs[i].rdata);
      @(negedge clk);
      chk($sformatf("row%0d bus_read", i),   32'(bus_read),   32'(vecs[i].e_rd));
      chk($sformatf("row%0d bus_write", i),  32'(bus_write),  32'(vecs[i].e_wr));
      chk($sformatf("row%0d instr_done", i), 32'(instr_done), 32'(vecs[i].e_idone));
      chk($sformatf("row%0d data_done", i),  32'(data_done),  32'(vecs[i].e_ddone));
      chk($sformatf("row%0d instr_rdata", i), instr_readdata, vecs[i].e_irdata);
      chk($sformatf("row%0d data_rdata", i),  data_readdata,  vecs[i].e_drdata);
      chk($sformatf("row%0d timeout", i), 32'(timeout_error), 32'h0);
      if (vecs[i].e_rd || vecs[i].e_wr) begin
        chk($sformatf("row%0d bus_addr", i), bus_address, vecs[i].e_addr);
        chk($sformatf("row%0d bus_be", i), 32'(bus_byteenable), 32'(vecs[i].e_be));
      end
      if (vecs[i].e_wr) chk($sformatf("row%0d bus_wdata", i), bus_writedata, 32'hDEADBEEF);
      step();
    end

    // Contended arbitration straight out of reset: instr, data, instr, data
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      automatic int  ph  = (c - 1) % 3;
      automatic bit  isi = (((c - 1) / 3) % 2) == 0;
      drive(c < 11, c < 11, 0, 0, 32'hA0000000 | 32'(c));
      @(negedge clk);
      chk($sformatf("arb c%0d strobe overlap", c), 32'(bus_read & bus_write), 32'h0);
      if (c >= 1) begin
        if (ph == 0) begin
          chk($sformatf("arb c%0d bus_read", c), 32'(bus_read), 32'h1);
          chk($sformatf("arb c%0d bus_addr", c), bus_address, isi ? 32'hBFC00000 : 32'h00001000);
        end else if (ph == 1) begin
          chk($sformatf("arb c%0d instr_done", c), 32'(instr_done), 32'(isi));
          chk($sformatf("arb c%0d data_done", c), 32'(data_done), 32'(!isi));
          chk($sformatf("arb c%0d rdata", c), isi ? instr_readdata : data_readdata,
              32'hA0000000 | 32'(c - 1));
        end else begin
          chk($sformatf("arb c%0d idle strobe", c), 32'(bus_read), 32'h0);
          chk($sformatf("arb c%0d idle done", c), 32'(instr_done | data_done), 32'h0);
        end
      end
      step();
    end

    // Watchdog abort on a stuck load, then sticky flag through a good fetch
    for (int c = 0; c <= 6; c++) begin
      drive(0, c < 5, 0, 1, 32'h77777777);
      @(negedge clk);
      if (c >= 1 && c <= 4) begin
        chk($sformatf("to c%0d bus_read", c), 32'(bus_read), 32'h1);
        chk($sformatf("to c%0d flag", c), 32'(timeout_error), 32'h0);
      end else if (c == 5) begin
        chk("to abort bus_read", 32'(bus_read), 32'h0);
        chk("to abort data_done", 32'(data_done), 32'h1);
        chk("to abort data_rdata", data_readdata, 32'h0);
        chk("to abort flag", 32'(timeout_error), 32'h1);
      end else if (c == 6) begin
        chk("to after data_done", 32'(data_done), 32'h0);
      end
      step();
    end
    for (int c = 0; c <= 3; c++) begin
      drive(c < 2, 0, 0, 0, 32'h11223344);
      @(negedge clk);
      if (c == 2) begin
        chk("to fetch instr_done", 32'(instr_done), 32'h1);
        chk("to fetch rdata", instr_readdata, 32'h11223344);
      end
      chk($sformatf("to sticky c%0d", c), 32'(timeout_error), 32'h1);
      step();
    end

    // Asynchronous reset in the middle of a stalled fetch
    drive(1, 0, 0, 1, 32'h0);
    step();
    @(negedge clk);
    chk("rst mid bus_read before", 32'(bus_read), 32'h1);
    step();
    #2 reset = 1'b1;
    #1;
    chk("rst async bus_read", 32'(bus_read), 32'h0);
    chk("rst async instr_done", 32'(instr_done), 32'h0);
    chk("rst async timeout", 32'(timeout_error), 32'h0);
    chk("rst async irdata", instr_readdata, 32'h0);
    drive(0, 0, 0, 0, 32'h0);
    step();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rst no done c%0d", c), 32'(instr_done | bus_read), 32'h0);
      step();
    end
    for (int c = 0; c <= 3; c++) begin
      drive(c < 2, 0, 0, 0, 32'h0BADF00D);
      @(negedge clk);
      if (c == 1) chk("rst refetch bus_read", 32'(bus_read), 32'h1);
      if (c == 2) begin
        chk("rst refetch done", 32'(instr_done), 32'h1);
        chk("rst refetch rdata", instr_readdata, 32'h0BADF00D);
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-requester arbiter sharing a single external memory bus (waitrequest-style read/write port) between the CPU instruction-fetch path and the load/store data path. It sits between the CPU core and the unified memory interface. It serializes accesses with round-robin priority, holds each grant until the slave completes the transfer, returns read data with a one-cycle done pulse, and flags stuck slaves through a timeout watchdog.

## Interface
- TIMEOUT_CYCLES, 255: maximum waitrequest-high cycles per access before abort (1..65535).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr_req  in  1  fetch request. Level; held with instr_address stable until instr_done.
- instr_address  in  32  fetch byte address.
- instr_readdata  out  32  fetched word. Valid while instr_done=1; held afterwards.
- instr_done  out  1  one-cycle completion pulse for the fetch.
- data_read  in  1  load request. Level; held until data_done.
- data_write  in  1  store request. Level; held until data_done. Wins over data_read if both are high.
- data_address  in  32  load/store byte address.
- data_writedata  in  32  store data.
- data_byteenable  in  4  store/load byte lanes.
- data_readdata  out  32  load result. Valid while data_done=1; held afterwards.
- data_done  out  1  one-cycle completion pulse for the data access.
- bus_address  out  32  memory address (registered).
- bus_read  out  1  memory read strobe (registered).
- bus_write  out  1  memory write strobe (registered).
- bus_writedata  out  32  memory write data (registered).
- bus_byteenable  out  4  memory byte enables. Fetch always 4'b1111.
- bus_waitrequest  in  1  slave stall. Transfer completes on an edge where a strobe is high and waitrequest is low.
- bus_readdata  in  32  memory read data, sampled at completion.
- timeout_error  out  1  sticky flag, set on any watchdog abort; cleared only by reset.

## Operation
- FSM states: IDLE, BUS_I, BUS_D, RESP.
- IDLE: sample requests. Data request = data_read|data_write.
  - Only one requester pending: grant it.
  - Both pending: grant the requester not granted last. The last-grant register resets to "data", so the first contended grant goes to instruction.
  - On grant, register the bus fields and move to BUS_I or BUS_D.
- BUS_I/BUS_D: strobe held with all bus fields stable.
  - On an edge with bus_waitrequest=0: capture bus_readdata into the granted requester's readdata register (stores leave data_readdata unchanged), drop the strobe, go to RESP.
- RESP: assert the granted done for exactly this cycle, then go to IDLE. Requests are not sampled in RESP, so the requester has one cycle to drop or change its request.
- Watchdog:
  - 16-bit counter, cleared on grant, incremented each BUS_* cycle with waitrequest=1.
  - When it reaches TIMEOUT_CYCLES, abort on that edge: drop the strobe, load readdata with 32'h0, set timeout_error, go to RESP. A normal done pulse follows.
- Strobes are never both high. bus_read/bus_write are high only in BUS_* states.

## Timing
- Reset (asynchronous, immediate) values:
  - State IDLE; last-grant = data.
  - All bus_* outputs 0; both done 0; both readdata 32'h0; timeout_error 0; watchdog counter 0.
- Reset during BUS_*/RESP aborts the access: no done pulse, strobes low at once.
- Latency: request high in cycle 0 → strobe high in cycle 1. With k waitrequest-high cycles, done is high in cycle 2+k. Minimum is 2.
- Throughput: one access per 3 cycles minimum (grant, bus, RESP). IDLE→grant happens on the cycle after RESP.
- Requests dropped while in IDLE before a grant are ignored (no access). Requests that change while granted are ignored until RESP.
- Done pulses for instruction and data never coincide.

## Test plan
- Single fetch, waitrequest=0, instr_address=32'hBFC00000, bus_readdata=32'h24020005 → bus_read in cycle 1 with bus_byteenable=4'b1111; instr_done in cycle 2 with instr_readdata=32'h24020005; data_done stays 0.
- Store with 3 waitrequest cycles: data_write=1, addr 32'h00001000, wdata 32'hDEADBEEF, be 4'b0011 → bus_write high cycles 1–4 with fields stable; data_done in cycle 5; data_readdata unchanged.
- Both requests held continuously across 4 grants → order instr, data, instr, data. Each access spans 3 cycles; no overlapping strobes.
- data_read and data_write both high → bus_write=1, bus_read=0.
- TIMEOUT_CYCLES=4, waitrequest stuck high on a load → strobe high 4 cycles, then dropped; data_done pulse with data_readdata=32'h0; timeout_error=1 and stays 1 through a later successful fetch.
- Assert reset in cycle 2 of a waitrequest-stalled fetch → bus_read falls asynchronously, no instr_done; after release a new fetch completes normally.
